// File: rtl/complex_vector_collector.sv
`default_nettype none
// ============================================================================
// Module   : complex_vector_collector
// Function : Packs NI-lane result chunks into an NOE-element vector buffer and
//            serves single-element reads to the next solver stage.
// Revision : 1.0
// ============================================================================
module complex_vector_collector #(
    parameter int NOE           = 19,
    parameter int NI            = 8,
    parameter int element_width = 64
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic                                         in_valid,
    input  logic [element_width*NI-1:0]                  in_chunk,
    output logic                                         busy,
    output logic                                         finish,
    output logic [$clog2(((NOE+NI-1)/NI)+1)-1:0]         chunk_count,
    output logic                                         overrun,
    input  logic                                         rd_en,
    input  logic [((NOE > 1) ? $clog2(NOE) : 1)-1:0]     rd_addr,
    output logic [element_width-1:0]                     rd_data,
    output logic                                         rd_valid
);

    localparam int CHUNKS = (NOE + NI - 1) / NI;
    localparam int AW     = (NOE > 1) ? $clog2(NOE) : 1;
    localparam int CW     = $clog2(CHUNKS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                   r_state_q;
    state_t                   w_state_d;
    logic [CW-1:0]            r_count_q;
    logic [CW-1:0]            w_count_d;
    logic                     r_overrun_q;
    logic                     w_overrun_d;
    logic                     w_accept;
    logic                     w_wr_en;

    logic [element_width-1:0] r_mem_q [NOE];
    logic [element_width-1:0] r_rd_data_q;
    logic                     r_rd_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= S_IDLE;
            r_count_q   <= '0;
            r_overrun_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_count_q   <= w_count_d;
            r_overrun_q <= w_overrun_d;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_count_d   = r_count_q;
        w_overrun_d = r_overrun_q;
        w_accept    = 1'b0;
        case (r_state_q)
            S_COLLECT: begin
                // start is deliberately ignored while a vector is in flight
                if (in_valid) begin
                    w_accept  = 1'b1;
                    w_count_d = r_count_q + 1'b1;
                    if (r_count_q == CW'(CHUNKS - 1)) begin
                        w_state_d = S_DONE;
                    end
                end
            end
            default: begin
                if (start) begin
                    w_state_d   = S_COLLECT;
                    w_count_d   = '0;
                    w_overrun_d = 1'b0;
                end else if (in_valid) begin
                    w_overrun_d = 1'b1;
                end
            end
        endcase
    end

    assign w_wr_en = w_accept & ~reset;

    // Each element belongs to a fixed chunk/lane; padding lanes have no element.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int e = 0; e < NOE; e++) begin
                if (r_count_q == CW'(e / NI)) begin
                    r_mem_q[e] <= in_chunk[element_width*(NI-(e%NI))-1 -: element_width];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data_q  <= '0;
            r_rd_valid_q <= 1'b0;
        end else begin
            r_rd_valid_q <= rd_en;
            if (rd_en) begin
                if ({1'b0, rd_addr} < (AW+1)'(NOE)) begin
                    r_rd_data_q <= r_mem_q[rd_addr];
                end else begin
                    r_rd_data_q <= '0;
                end
            end
        end
    end

    assign busy        = (r_state_q == S_COLLECT);
    assign finish      = (r_state_q == S_DONE);
    assign chunk_count = r_count_q;
    assign overrun     = r_overrun_q;
    assign rd_data     = r_rd_data_q;
    assign rd_valid    = r_rd_valid_q;

endmodule
`default_nettype wire
